// File: rtl/operand_fetch.sv
// Operand-fetch stage: 32-entry integer register file, operand select with
// write-back bypass, and a single-entry valid/ready buffer feeding the ALU.
module operand_fetch #(
  parameter int XLEN = 64,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  input  logic [XLEN-1:0] imm,
  input  logic            use_imm,
  input  logic            sub_in,
  input  logic [4:0]      rd_in,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] s1,
  output logic [XLEN-1:0] s2,
  output logic            sub,
  output logic [4:0]      rd_out,
  input  logic [4:0]      dbg_addr,
  output logic [XLEN-1:0] dbg_data
);

  typedef struct packed {
    logic [XLEN-1:0] s1;
    logic [XLEN-1:0] s2;
    logic            sub;
    logic [4:0]      rd;
  } op_t;

  logic [XLEN-1:0] rf_q [NREG];
  logic [XLEN-1:0] rf_d [NREG];
  op_t             op_q, op_d;
  logic            out_valid_q, out_valid_d;
  logic            wb_hit;
  logic            accept;
  logic [XLEN-1:0] src1, src2;

  assign wb_hit   = wb_en && (wb_addr != 5'd0);
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Entry 0 is never written, so it holds its reset value of zero.
  always_comb begin
    rf_d = rf_q;
    if (wb_hit) rf_d[wb_addr] = wb_data;
  end

  // Same-cycle write-back is forwarded so the operand sees the new value.
  always_comb begin
    src1 = '0;
    src2 = '0;
    if (rs1 != 5'd0) src1 = (wb_hit && wb_addr == rs1) ? wb_data : rf_q[rs1];
    if (rs2 != 5'd0) src2 = (wb_hit && wb_addr == rs2) ? wb_data : rf_q[rs2];
  end

  always_comb begin
    op_d        = op_q;
    out_valid_d = out_valid_q;
    if (accept) begin
      op_d.s1     = src1;
      op_d.s2     = use_imm ? imm : src2;
      op_d.sub    = sub_in && !use_imm;
      op_d.rd     = rd_in;
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
      op_q        <= '0;
      out_valid_q <= 1'b0;
    end else begin
      rf_q        <= rf_d;
      op_q        <= op_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign s1        = op_q.s1;
  assign s2        = op_q.s2;
  assign sub       = op_q.sub;
  assign rd_out    = op_q.rd;
  assign dbg_data  = (dbg_addr == 5'd0) ? '0 : rf_q[dbg_addr];

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: reset, operands, bypass, immediate,
// backpressure, back-to-back issue and mid-operation reset.
module tb_operand_fetch;
  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid, in_ready;
  logic [4:0]      rs1, rs2, rd_in, wb_addr, dbg_addr, rd_out;
  logic [XLEN-1:0] imm, wb_data, s1, s2, dbg_data;
  logic            use_imm, sub_in, wb_en, out_valid, out_ready, sub;

  int checks = 0;
  int errors = 0;

  operand_fetch #(.XLEN(XLEN), .NREG(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .rs1(rs1), .rs2(rs2), .imm(imm), .use_imm(use_imm), .sub_in(sub_in),
    .rd_in(rd_in), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .s1(s1), .s2(s2),
    .sub(sub), .rd_out(rd_out), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; rs1 = 0; rs2 = 0; imm = '0; use_imm = 0; sub_in = 0;
    rd_in = 0; wb_en = 0; wb_addr = 0; wb_data = '0;
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [XLEN-1:0] d);
    wb_en = 1; wb_addr = a; wb_data = d;
    step();
    wb_en = 0;
  endtask

  task automatic issue(input logic [4:0] r1, input logic [4:0] r2, input logic sb,
                       input logic [4:0] rd);
    in_valid = 1; rs1 = r1; rs2 = r2; sub_in = sb; rd_in = rd; use_imm = 0;
    step();
    in_valid = 0;
  endtask

  task automatic test_reset();
    rst_n = 1; out_ready = 1;
    write_reg(5'd3, 64'd123);
    write_reg(5'd31, 64'd55);
    issue(5'd3, 5'd31, 1'b1, 5'd4);
    rst_n = 0;
    step();
    rst_n = 1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", out_valid); end
    checks++; if (s1 !== '0 || s2 !== '0) begin errors++; $display("FAIL reset_operands got s1=%0d s2=%0d want 0", s1, s2); end
    checks++; if (sub !== 1'b0 || rd_out !== 5'd0) begin errors++; $display("FAIL reset_ctrl got sub=%0b rd=%0d want 0", sub, rd_out); end
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      #1;
      checks++;
      if (dbg_data !== '0) begin errors++; $display("FAIL reset_rf x%0d got %0d want 0", i, dbg_data); end
    end
  endtask

  task automatic test_reg_operands();
    out_ready = 1;
    write_reg(5'd5, 64'd450);
    write_reg(5'd6, 64'd47);
    issue(5'd5, 5'd6, 1'b1, 5'd7);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL reg_valid got %0b want 1", out_valid); end
    checks++; if (s1 !== 64'd450 || s2 !== 64'd47) begin errors++; $display("FAIL reg_operands got s1=%0d s2=%0d want 450 47", s1, s2); end
    checks++; if (sub !== 1'b1 || rd_out !== 5'd7) begin errors++; $display("FAIL reg_ctrl got sub=%0b rd=%0d want 1 7", sub, rd_out); end
    checks++; if ((sub ? s1 - s2 : s1 + s2) !== 64'd403) begin errors++; $display("FAIL alu_sub got %0d want 403", sub ? s1 - s2 : s1 + s2); end
    issue(5'd5, 5'd6, 1'b0, 5'd7);
    checks++; if ((sub ? s1 - s2 : s1 + s2) !== 64'd497) begin errors++; $display("FAIL alu_add got %0d want 497", sub ? s1 - s2 : s1 + s2); end
    step();
    checks++; if (out_valid !== 1'b0 || s1 !== 64'd450) begin errors++; $display("FAIL drain got valid=%0b s1=%0d want 0 450", out_valid, s1); end
  endtask

  task automatic test_bypass();
    out_ready = 1;
    wb_en = 1; wb_addr = 5'd9; wb_data = 64'd1000;
    issue(5'd9, 5'd0, 1'b0, 5'd1);
    wb_en = 0;
    checks++; if (s1 !== 64'd1000 || s2 !== '0) begin errors++; $display("FAIL bypass1 got s1=%0d s2=%0d want 1000 0", s1, s2); end
    wb_en = 1; wb_addr = 5'd9; wb_data = 64'd2000;
    issue(5'd9, 5'd9, 1'b0, 5'd2);
    wb_en = 0;
    checks++; if (s1 !== 64'd2000 || s2 !== 64'd2000) begin errors++; $display("FAIL bypass_same got s1=%0d s2=%0d want 2000 2000", s1, s2); end
    write_reg(5'd9, 64'd1000);
    write_reg(5'd0, 64'hFFFF);
    dbg_addr = 5'd0; #1;
    checks++; if (dbg_data !== '0) begin errors++; $display("FAIL x0_write got %0d want 0", dbg_data); end
    issue(5'd0, 5'd0, 1'b0, 5'd0);
    checks++; if (s1 !== '0 || s2 !== '0) begin errors++; $display("FAIL x0_read got s1=%0d s2=%0d want 0 0", s1, s2); end
    step();
  endtask

  task automatic test_imm();
    out_ready = 1;
    in_valid = 1; rs1 = 5'd5; rs2 = 5'd6; use_imm = 1; sub_in = 1; rd_in = 5'd3;
    imm = 64'hFFFF_FFFF_FFFF_FFFB;
    step();
    in_valid = 0; use_imm = 0; sub_in = 0;
    checks++; if (s1 !== 64'd450 || s2 !== 64'hFFFF_FFFF_FFFF_FFFB) begin errors++; $display("FAIL imm_operands got s1=%0d s2=%h want 450 fffffffffffffffb", s1, s2); end
    checks++; if (sub !== 1'b0) begin errors++; $display("FAIL imm_sub got %0b want 0", sub); end
    step();
  endtask

  task automatic test_stall();
    out_ready = 1;
    issue(5'd5, 5'd6, 1'b0, 5'd8);
    out_ready = 0;
    in_valid = 1; rs1 = 5'd6; rs2 = 5'd0; rd_in = 5'd10;
    wb_en = 1; wb_addr = 5'd5; wb_data = 64'd7;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready got %0b want 0", in_ready); end
    for (int c = 0; c < 3; c++) begin
      step();
      wb_en = 0;
      checks++;
      if (out_valid !== 1'b1 || s1 !== 64'd450 || rd_out !== 5'd8 || in_ready !== 1'b0) begin
        errors++; $display("FAIL stall_hold c%0d got v=%0b s1=%0d rd=%0d rdy=%0b want 1 450 8 0", c, out_valid, s1, rd_out, in_ready);
      end
    end
    dbg_addr = 5'd5; #1;
    checks++; if (dbg_data !== 64'd7) begin errors++; $display("FAIL stall_wb got %0d want 7", dbg_data); end
    out_ready = 1; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_ready got %0b want 1", in_ready); end
    step();
    in_valid = 0;
    checks++; if (out_valid !== 1'b1 || s1 !== 64'd47 || rd_out !== 5'd10) begin errors++; $display("FAIL release got v=%0b s1=%0d rd=%0d want 1 47 10", out_valid, s1, rd_out); end
    step();
  endtask

  task automatic test_back_to_back();
    logic [XLEN-1:0] exp [3];
    logic [4:0]      src [3];
    exp[0] = 64'd7; exp[1] = 64'd47; exp[2] = 64'd1000;
    src[0] = 5'd5;  src[1] = 5'd6;   src[2] = 5'd9;
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; rs1 = src[i]; rs2 = 5'd0; rd_in = 5'(i + 1); use_imm = 0;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready %0d got %0b want 1", i, in_ready); end
      step();
      checks++;
      if (out_valid !== 1'b1 || s1 !== exp[i] || rd_out !== 5'(i + 1)) begin
        errors++; $display("FAIL b2b %0d got v=%0b s1=%0d rd=%0d want 1 %0d %0d", i, out_valid, s1, rd_out, exp[i], i + 1);
      end
    end
    in_valid = 0;
    step();
  endtask

  task automatic test_reset_mid();
    out_ready = 1;
    issue(5'd5, 5'd6, 1'b1, 5'd12);
    out_ready = 0;
    rst_n = 0;
    wb_en = 1; wb_addr = 5'd4; wb_data = 64'd99;
    step();
    rst_n = 1; wb_en = 0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL midreset_hs got v=%0b rdy=%0b want 0 1", out_valid, in_ready); end
    dbg_addr = 5'd5; #1;
    checks++; if (dbg_data !== '0) begin errors++; $display("FAIL midreset_x5 got %0d want 0", dbg_data); end
    dbg_addr = 5'd4; #1;
    checks++; if (dbg_data !== '0) begin errors++; $display("FAIL midreset_wb got %0d want 0", dbg_data); end
  endtask

  initial begin
    idle_inputs();
    rst_n = 0; out_ready = 1; dbg_addr = 0;
    step();
    step();
    test_reset();
    test_reg_operands();
    test_bypass();
    test_imm();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Operand-fetch stage directly upstream of the datapath ALU (`ula`).
- Holds the 32 x XLEN integer register file and selects operands: register or immediate for `s2`.
- Registers `s1`, `s2`, `sub` and the destination tag into a single-entry pipeline buffer with a valid/ready handshake, which feeds the ALU inputs.
- Accepts write-back from the downstream stage.

Parameters:
- XLEN, 64, operand/register width in bits.
- NREG, 32, number of architectural registers. Address width is fixed at 5 bits; `x0` is hardwired to zero.

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  synchronous, active-low reset
- in_valid  input  1  upstream presents an operation
- in_ready  output  1  stage can accept an operation this cycle
- rs1  input  5  source register 1 index
- rs2  input  5  source register 2 index
- imm  input  XLEN  sign-extended immediate
- use_imm  input  1  1: `s2` = `imm`; 0: `s2` = `rf[rs2]`
- sub_in  input  1  ALU subtract request
- rd_in  input  5  destination register tag, passed through
- wb_en  input  1  write-back enable
- wb_addr  input  5  write-back register index
- wb_data  input  XLEN  write-back value
- out_valid  output  1  `s1`/`s2`/`sub`/`rd_out` hold a valid operation
- out_ready  input  1  ALU/downstream consumes the operation
- s1  output  XLEN  ALU operand 1 (registered)
- s2  output  XLEN  ALU operand 2 (registered)
- sub  output  1  ALU subtract control (registered)
- rd_out  output  5  destination tag (registered)
- dbg_addr  input  5  debug read index
- dbg_data  output  XLEN  combinational read of `rf[dbg_addr]`; `x0` reads 0

Behaviour:
- Reset (`rst_n`=0 at a rising edge):
  - All registers `x1..x31` cleared to 0.
  - `out_valid`=0, `s1`=0, `s2`=0, `sub`=0, `rd_out`=0.
  - Applies mid-operation: a buffered operation is discarded, and a write-back in the same cycle is ignored.
- Handshake:
  - `in_ready` = !`out_valid` || `out_ready` (combinational).
  - accept = `in_valid` && `in_ready`.
- Latency and throughput: 1 cycle. An operation accepted at edge N appears on the outputs with `out_valid`=1 after edge N. Back-to-back acceptance gives full throughput while `out_ready`=1.
- Output buffer update at each edge:
  - If accept: load new operands; `out_valid`<=1.
  - Else if `out_valid` && `out_ready`: `out_valid`<=0; data outputs keep their last values.
  - Else: hold.
- Operand selection on accept:
  - `s1` = `rs1`==0 ? 0 : (bypass1 ? `wb_data` : `rf[rs1]`).
  - bypass1 = `wb_en` && `wb_addr`==`rs1` && `wb_addr`!=0.
  - `s2` = `use_imm` ? `imm` : same rule applied to `rs2`.
  - `sub` = `sub_in` && !`use_imm`. There is no subtract-immediate; `sub` is forced to 0 when `use_imm`=1.
  - `rd_out` = `rd_in`.
- Write-back:
  - If `wb_en` && `wb_addr`!=0, `rf[wb_addr]` <= `wb_data` at the edge.
  - Writes to `x0` are dropped.
  - Writes proceed regardless of stall or handshake state.
- Stall hold: while `out_valid`=1 && `out_ready`=0, `s1`/`s2`/`sub`/`rd_out` stay stable. A write-back to a captured source register does NOT update the buffered operand; RAW hazards against a stalled entry are resolved by the hazard unit.
- Simultaneous same-cycle events are all legal and follow the rules above:
  - accept plus drain;
  - accept plus write-back to a source register (bypass applies);
  - `rs1`==`rs2`.
- No X on outputs after reset; `dbg_data` is purely combinational.

Test Plan:
- Reset: hold `rst_n`=0 for 1 cycle after arbitrary writes -> `out_valid`=0, `s1`=`s2`=0, `dbg_data`=0 for all 32 addresses.
- Register operands:
  - Stimulus: write `x5`=450 and `x6`=47; then `in_valid`=1, `rs1`=5, `rs2`=6, `sub_in`=1, `rd_in`=7, `out_ready`=1.
  - Response: next cycle `out_valid`=1, `s1`=450, `s2`=47, `sub`=1, `rd_out`=7. The ALU driven from these outputs yields 403; with `sub_in`=0 it yields 497.
- Bypass and `x0`:
  - Same cycle `wb_en`=1, `wb_addr`=9, `wb_data`=1000 with fetch `rs1`=9, `rs2`=0 -> `s1`=1000, `s2`=0.
  - Write `x0`=0xFFFF -> `dbg_data`(0)=0.
- Immediate: `use_imm`=1, `imm`=0xFFFF_FFFF_FFFF_FFFB (-5), `sub_in`=1, `rs1`=5 (450) -> `s1`=450, `s2`=-5, `sub`=0.
- Stall/backpressure:
  - Stimulus: with an operation buffered, drive `out_ready`=0 for 3 cycles while `in_valid`=1 (new `rs1`=6) and write `x5`=7.
  - During the stall: `in_ready`=0, and outputs are unchanged (`s1`=450).
  - After `out_ready`=1: the new operation is accepted the same cycle and `s1`=47 appears next cycle.
- Reset mid-operation: with `out_valid`=1 and `out_ready`=0, assert `rst_n`=0 for 1 cycle -> `out_valid`=0, `in_ready`=1, `x5` reads 0.
